// File: rtl/ir_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ir_fetch_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTR_W  = 8;

    localparam int unsigned        TIMEOUT_DEFAULT  = 16;
    localparam logic [DATA_W-1:0]  NOP_WORD_DEFAULT = 32'hE1A0_0000;
    localparam logic [CTR_W-1:0]   CTR_MAX          = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/ir_fetch_unit_timeout_ctr.sv
// Saturating wait-cycle counter with clear/enable and a terminal-count flag at LIMIT-1.
module ir_fetch_unit_timeout_ctr
    import ir_fetch_unit_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c_o
);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CTR_MAX)) begin
            cnt_d = cnt_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == CTR_W'(LIMIT - 1));

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction-fetch stage: one imem read per write_ir request, with timeout
// substitution of NOP_WORD and a flush path for redirected fetches.
module ir_fetch_unit
    import ir_fetch_unit_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_ir,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] IR_buf,
    output logic              W_IR_valid,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    logic              armed_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_buf_q;
    logic              valid_q;
    logic              err_q;

    logic fetch_start_c;
    logic ctr_en_c;
    logic ctr_tc_c;

    // A new fetch needs write_ir to have been seen low since the previous one.
    assign fetch_start_c = (state_q == ST_IDLE) && write_ir && armed_q && !flush;
    assign ctr_en_c      = (state_q == ST_REQ) && !flush && !imem_ack && !ctr_tc_c;

    ir_fetch_unit_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_fetch_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (fetch_start_c),
        .en_i   (ctr_en_c),
        .tc_c_o (ctr_tc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            armed_q  <= 1'b1;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ir_q     <= '0;
            ir_buf_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (!write_ir) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fetch_start_c) begin
                        addr_q  <= word_align(pc);
                        req_q   <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                // Flush beats ack beats timeout.
                ST_REQ: begin
                    if (flush) begin
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (imem_ack) begin
                        ir_q     <= imem_rdata;
                        ir_buf_q <= imem_rdata;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= ST_VALID;
                    end else if (ctr_tc_c) begin
                        ir_q     <= NOP_WORD;
                        ir_buf_q <= NOP_WORD;
                        err_q    <= 1'b1;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign IR         = ir_q;
    assign IR_buf     = ir_buf_q;
    assign fetch_err  = err_q;
    // A flush during the valid cycle suppresses the pulse without waiting for an edge.
    assign W_IR_valid = valid_q && !flush;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: directed scenarios plus randomized
// fetches checked against a per-transaction outcome model.
module tb_ir_fetch_unit;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_ir;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IR;
    logic [31:0] IR_buf;
    logic        W_IR_valid;
    logic        fetch_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ir = '0;
    logic        exp_err = 1'b0;

    ir_fetch_unit #(
        .TIMEOUT  (TIMEOUT),
        .NOP_WORD (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_ir   (write_ir),
        .flush      (flush),
        .pc         (pc),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .IR         (IR),
        .IR_buf     (IR_buf),
        .W_IR_valid (W_IR_valid),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; one-cycle pulses (ack, flush) are released right after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    // Drives one fetch like the control FSM would (write_ir held high) and measures the outcome.
    // lat: REQ cycle carrying ack (0 = never); flush_at: REQ cycle carrying flush (0 = none).
    task automatic run_fetch(input logic [31:0] pcv, input int lat, input logic [31:0] data,
                             input int flush_at, output int req_cycles, output int pulses,
                             output int vstep, output logic [31:0] addr_seen, output bit addr_stable);
        req_cycles  = 0;
        pulses      = 0;
        vstep       = 0;
        addr_stable = 1'b1;
        pc          = pcv;
        write_ir    = 1'b1;
        step();
        addr_seen = imem_addr;
        for (int n = 1; n <= TIMEOUT + 6; n++) begin
            if (imem_req === 1'b1) begin
                req_cycles++;
                if (imem_addr !== addr_seen) addr_stable = 1'b0;
            end
            if (W_IR_valid === 1'b1) begin
                pulses++;
                if (vstep == 0) vstep = n;
            end
            if (n == 2) pc = $urandom;
            imem_rdata = $urandom;
            if (n == lat) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
            end
            if (n == flush_at) flush = 1'b1;
            step();
        end
        write_ir = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; write_ir = 1'b0; flush = 1'b0; pc = '0; imem_rdata = '0; imem_ack = 1'b0;
        #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        n_cmp++; if (IR !== 32'h0 || IR_buf !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h/%h expected 0/0", IR, IR_buf); end
        n_cmp++; if (W_IR_valid !== 1'b0 || fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b/%b expected 0/0", W_IR_valid, fetch_err); end
        step(); step();
        rst = 1'b0;
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: got %b expected 0", imem_req); end
    endtask

    task automatic test_basic_fetch();
        int r, p, v; logic [31:0] a; bit st;
        run_fetch(32'h0000_0010, 3, 32'hEA00_0004, 0, r, p, v, a, st);
        exp_ir = 32'hEA00_0004;
        n_cmp++; if (a !== 32'h10) begin n_bad++; $display("FAIL basic_addr: got %h expected 00000010", a); end
        n_cmp++; if (r != 3) begin n_bad++; $display("FAIL basic_req_cycles: got %0d expected 3", r); end
        n_cmp++; if (p != 1) begin n_bad++; $display("FAIL basic_valid_pulses: got %0d expected 1", p); end
        n_cmp++; if (v != 4) begin n_bad++; $display("FAIL basic_valid_cycle: got %0d expected 4", v); end
        n_cmp++; if (IR !== exp_ir || IR_buf !== exp_ir) begin n_bad++; $display("FAIL basic_ir: got %h/%h expected %h", IR, IR_buf, exp_ir); end
    endtask

    task automatic test_rearm();
        int r, p, v; logic [31:0] a; bit st; logic [31:0] d;
        d = $urandom;
        run_fetch(32'h0000_0100, 1, d, 0, r, p, v, a, st);
        exp_ir = d;
        n_cmp++; if (v != 2) begin n_bad++; $display("FAIL minlat_valid_cycle: got %0d expected 2", v); end
        n_cmp++; if (r != 1) begin n_bad++; $display("FAIL rearm_single_req: got %0d expected 1", r); end
        n_cmp++; if (p != 1) begin n_bad++; $display("FAIL rearm_single_pulse: got %0d expected 1", p); end
        d = $urandom;
        run_fetch(32'h0000_0104, 2, d, 0, r, p, v, a, st);
        exp_ir = d;
        n_cmp++; if (r != 2 || IR !== exp_ir) begin n_bad++; $display("FAIL rearm_second_fetch: got req=%0d IR=%h expected req=2 IR=%h", r, IR, exp_ir); end
    endtask

    task automatic test_timeout();
        int r, p, v; logic [31:0] a; bit st; logic [31:0] d;
        run_fetch(32'h0000_0200, 0, 32'h0, 0, r, p, v, a, st);
        exp_ir = NOP; exp_err = 1'b1;
        n_cmp++; if (r != TIMEOUT) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d expected %0d", r, TIMEOUT); end
        n_cmp++; if (p != 1 || v != TIMEOUT + 1) begin n_bad++; $display("FAIL timeout_valid: got pulses=%0d cycle=%0d expected 1/%0d", p, v, TIMEOUT + 1); end
        n_cmp++; if (IR !== NOP || IR_buf !== NOP) begin n_bad++; $display("FAIL timeout_nop: got %h/%h expected %h", IR, IR_buf, NOP); end
        n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b expected 1", fetch_err); end
        d = $urandom;
        run_fetch(32'h0000_0204, 5, d, 0, r, p, v, a, st);
        exp_ir = d;
        n_cmp++; if (fetch_err !== 1'b1 || IR !== exp_ir) begin n_bad++; $display("FAIL err_sticky: got err=%b IR=%h expected 1/%h", fetch_err, IR, exp_ir); end
    endtask

    task automatic test_flush();
        int r, p, v; logic [31:0] a; bit st; logic [31:0] d;
        run_fetch(32'h0000_0300, 2, 32'h1234_5678, 2, r, p, v, a, st);
        n_cmp++; if (r != 2) begin n_bad++; $display("FAIL flush_req_cycles: got %0d expected 2", r); end
        n_cmp++; if (p != 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d expected 0", p); end
        n_cmp++; if (IR !== exp_ir || IR_buf !== exp_ir) begin n_bad++; $display("FAIL flush_ir_kept: got %h/%h expected %h", IR, IR_buf, exp_ir); end
        d = $urandom;
        run_fetch(32'h0000_0304, 3, d, 0, r, p, v, a, st);
        exp_ir = d;
        n_cmp++; if (r != 3 || p != 1 || IR !== exp_ir) begin n_bad++; $display("FAIL after_flush_fetch: got req=%0d pulses=%0d IR=%h expected 3/1/%h", r, p, IR, exp_ir); end
        // Flush landing on the valid cycle itself.
        d = $urandom;
        pc = 32'h0000_0308; write_ir = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = d;
        step();
        exp_ir = d;
        n_cmp++; if (W_IR_valid !== 1'b1) begin n_bad++; $display("FAIL valid_before_flush: got %b expected 1", W_IR_valid); end
        flush = 1'b1;
        #1;
        n_cmp++; if (W_IR_valid !== 1'b0) begin n_bad++; $display("FAIL flush_masks_valid: got %b expected 0", W_IR_valid); end
        n_cmp++; if (IR !== exp_ir) begin n_bad++; $display("FAIL flush_valid_ir: got %h expected %h", IR, exp_ir); end
        step();
        write_ir = 1'b0;
        step();
    endtask

    task automatic test_alignment();
        int r, p, v; logic [31:0] a; bit st; logic [31:0] d;
        d = $urandom;
        run_fetch(32'h0000_0013, 4, d, 0, r, p, v, a, st);
        exp_ir = d;
        n_cmp++; if (a !== 32'h0000_0010) begin n_bad++; $display("FAIL align_addr: got %h expected 00000010", a); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL addr_stable_pc_change: got %b expected 1", st); end
    endtask

    task automatic test_random();
        int r, p, v, lat, fl, endc, er, ep, ev; logic [31:0] a, d, pcv; bit st;
        for (int i = 0; i < 24; i++) begin
            lat  = int'($urandom_range(TIMEOUT + 2, 1));
            d    = $urandom;
            pcv  = $urandom;
            endc = (lat <= TIMEOUT) ? lat : TIMEOUT;
            fl   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(endc, 1)) : 0;
            run_fetch(pcv, lat, d, fl, r, p, v, a, st);
            if (fl != 0) begin
                er = fl; ep = 0; ev = 0;
            end else if (lat <= TIMEOUT) begin
                er = lat; ep = 1; ev = lat + 1; exp_ir = d;
            end else begin
                er = TIMEOUT; ep = 1; ev = TIMEOUT + 1; exp_ir = NOP; exp_err = 1'b1;
            end
            n_cmp++; if (r != er || p != ep || v != ev) begin n_bad++; $display("FAIL rand%0d_timing: got req=%0d pulses=%0d vcyc=%0d expected %0d/%0d/%0d", i, r, p, v, er, ep, ev); end
            n_cmp++; if (IR !== exp_ir || IR_buf !== exp_ir) begin n_bad++; $display("FAIL rand%0d_ir: got %h/%h expected %h", i, IR, IR_buf, exp_ir); end
            n_cmp++; if (a !== (pcv & ~32'h3) || st !== 1'b1) begin n_bad++; $display("FAIL rand%0d_addr: got %h stable=%b expected %h stable=1", i, a, st, pcv & ~32'h3); end
            n_cmp++; if (fetch_err !== exp_err) begin n_bad++; $display("FAIL rand%0d_err: got %b expected %b", i, fetch_err, exp_err); end
        end
    endtask

    task automatic test_async_reset();
        pc = 32'h0000_0400; write_ir = 1'b1;
        step();
        step();
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL pre_reset_req: got %b expected 1", imem_req); end
        #2;
        rst = 1'b1; write_ir = 1'b0;
        #1;
        exp_ir = '0; exp_err = 1'b0;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL async_rst_req: got %b/%h expected 0/0", imem_req, imem_addr); end
        n_cmp++; if (IR !== 32'h0 || IR_buf !== 32'h0 || fetch_err !== 1'b0) begin n_bad++; $display("FAIL async_rst_regs: got %h/%h/%b expected 0/0/0", IR, IR_buf, fetch_err); end
        step();
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        n_cmp++; if (W_IR_valid !== 1'b0 || IR !== 32'h0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL late_ack_ignored: got valid=%b IR=%h req=%b expected 0/0/0", W_IR_valid, IR, imem_req); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL err_after_reset: got %b expected 0", fetch_err); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_rearm();
        test_timeout();
        test_flush();
        test_alignment();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ir_fetch_unit.md
Name: ir_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multi-cycle control FSM.
- On the FSM's fetch request (write_ir), issues a single-word read to instruction memory over a req/ack handshake with variable latency.
- Captures the returned word into IR and IR_buf, then pulses W_IR_valid so the FSM can leave its fetch state.
- Provides timeout protection and a flush path for redirected fetches.

Parameters:
- TIMEOUT, 16: max cycles imem_req stays high without imem_ack before the fetch is abandoned; legal range 2..255.
- NOP_WORD, 32'hE1A00000: word substituted into IR/IR_buf on timeout (MOV r0,r0).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- write_ir  in  1  fetch request/level from control FSM (high while FSM is in fetch state).
- flush  in  1  synchronous abort of any fetch in progress.
- pc  in  32  fetch address, sampled when a fetch starts.
- imem_rdata  in  32  instruction memory read data, valid when imem_ack=1.
- imem_ack  in  1  memory acknowledge, one-cycle pulse.
- imem_req  out  1  memory read request, held until ack, timeout or flush.
- imem_addr  out  32  registered fetch address; word aligned (bits[1:0] forced 0).
- IR  out  32  committed instruction register.
- IR_buf  out  32  raw fetch buffer; last word returned by memory, or NOP_WORD on timeout.
- W_IR_valid  out  1  one-cycle pulse: IR/IR_buf hold a newly fetched word.
- fetch_err  out  1  sticky timeout flag; cleared only by rst.

Behaviour:
- Reset: all outputs 0, state IDLE, armed=1, wait counter 0. Async reset mid-fetch abandons the fetch immediately; a late ack arriving after reset is ignored.
- States: IDLE, REQ, VALID.
- IDLE: if write_ir=1 and armed=1 and flush=0, then on the posedge:
  - imem_addr <= {pc[31:2],2'b00}
  - imem_req <= 1, counter <= 0, armed <= 0
  - go to REQ.
  - Otherwise stay in IDLE.
- armed: set whenever write_ir is sampled 0. This re-arm rule prevents a second fetch while the FSM's write_ir is still high after W_IR_valid.
- REQ, priority order:
  1. flush=1: imem_req <= 0, go IDLE. An ack in the same cycle is discarded; IR and IR_buf are unchanged.
  2. imem_ack=1: IR <= imem_rdata, IR_buf <= imem_rdata, imem_req <= 0, W_IR_valid <= 1, go VALID.
  3. counter = TIMEOUT-1: IR <= NOP_WORD, IR_buf <= NOP_WORD, fetch_err <= 1, imem_req <= 0, W_IR_valid <= 1, go VALID.
  4. Otherwise: counter <= counter + 1. The counter saturates; it never wraps.
- Minimum latency: write_ir sampled → imem_req high next cycle. Ack in the first REQ cycle → W_IR_valid high the cycle after. Total: 2 cycles from request to valid.
- VALID (exactly one cycle): W_IR_valid <= 0 on exit, go IDLE. If flush=1 during VALID, W_IR_valid is forced low combinationally that cycle; IR keeps the fetched word.
- IR and IR_buf change only on ack or timeout; they hold their value at all other times.
- imem_addr is stable for the entire REQ interval; pc changes during REQ are ignored.
- A spurious imem_ack in IDLE or VALID is ignored.
- At most one outstanding request at any time.
- Counter width: 8 bits.

Decomposition:
- Shared package: state encoding constants (IDLE/REQ/VALID), NOP_WORD, default TIMEOUT.
- One natural sub-module: fetch_timeout_ctr (8-bit saturating counter with clear, enable and terminal-count output).

Test Plan:
- Reset, then write_ir=1, pc=32'h0000_0010, ack after 3 cycles with rdata=32'hEA00_0004 → imem_addr=32'h10; imem_req high for 3 cycles; IR=IR_buf=32'hEA000004; W_IR_valid high for exactly 1 cycle.
- Ack in the first REQ cycle → W_IR_valid asserted 2 cycles after write_ir was sampled. Hold write_ir high 2 more cycles → no second imem_req until write_ir has been sampled 0 and then 1 again.
- No ack, TIMEOUT=16 → imem_req high for exactly 16 cycles, then IR=IR_buf=32'hE1A00000, fetch_err=1 (sticky), W_IR_valid pulses once.
- flush in the 2nd REQ cycle coinciding with ack, rdata=32'h1234_5678 → imem_req drops, IR unchanged, no W_IR_valid pulse; the next fetch proceeds normally.
- pc=32'h0000_0013 → imem_addr=32'h0000_0010. pc changed mid-REQ → imem_addr unchanged.
- rst asserted mid-REQ → all outputs 0 asynchronously. A late ack after reset is ignored; fetch_err=0.
